// File: rtl/freelist_rename_n.sv
// N-wide physical register freelist for rename.
// Circular FIFO of free pregs with per-branch head checkpoints.
module freelist_rename_n #(
  parameter int NUM_PREGS = 80,
  parameter int NUM_AREGS = 16,
  parameter int ALLOC_W = 2,
  parameter int FREE_W = 2,
  parameter int MAX_PREDICT_DEPTH = 4,
  localparam int PREG_BITS = $clog2(NUM_PREGS),
  localparam int TAG_BITS = $clog2(MAX_PREDICT_DEPTH),
  localparam int FL_DEPTH = NUM_PREGS - NUM_AREGS,
  localparam int IDX_BITS = $clog2(FL_DEPTH),
  localparam int CNT_BITS = IDX_BITS + 1
) (
  input  logic clk,
  input  logic reset,
  input  logic alloc_valid,
  input  logic [ALLOC_W-1:0] alloc_req,
  output logic alloc_ready,
  output logic [ALLOC_W*PREG_BITS-1:0] alloc_preg,
  output logic [CNT_BITS-1:0] num_free,
  input  logic checkpoint_valid,
  input  logic [TAG_BITS-1:0] checkpoint_tag,
  input  logic branch_shootdown,
  input  logic [TAG_BITS-1:0] shootdown_branch_tag,
  input  logic [FREE_W-1:0] free_valid,
  input  logic [FREE_W*PREG_BITS-1:0] free_addr,
  output logic overflow_err
);

  if ((FL_DEPTH & (FL_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("freelist depth must be a power of two");
  end

  logic [PREG_BITS-1:0] entries [FL_DEPTH];
  logic [CNT_BITS-1:0] head;
  logic [CNT_BITS-1:0] tail;
  logic [CNT_BITS-1:0] ckpt_head [MAX_PREDICT_DEPTH];

  logic [CNT_BITS-1:0] need;
  logic [CNT_BITS-1:0] rank;
  logic [IDX_BITS-1:0] a_idx;
  logic fire;
  logic [CNT_BITS-1:0] head_adv;

  logic [CNT_BITS-1:0] space;
  logic [CNT_BITS-1:0] acc;
  logic [FREE_W-1:0] wr_en;
  logic [IDX_BITS-1:0] wr_idx [FREE_W];
  logic drop;

  assign num_free = tail - head;

  // Count requesting lanes in the decode group.
  always_comb begin
    need = '0;
    for (int i = 0; i < ALLOC_W; i++) begin
      need = need + CNT_BITS'(alloc_req[i]);
    end
  end

  assign alloc_ready = !branch_shootdown
                     && (num_free >= need);
  assign fire = alloc_valid && alloc_ready;
  assign head_adv = fire ? head + need : head;

  // Pack requesting lanes onto consecutive list slots.
  always_comb begin
    rank = '0;
    a_idx = '0;
    alloc_preg = '0;
    for (int i = 0; i < ALLOC_W; i++) begin
      if (alloc_req[i]) begin
        a_idx = head[IDX_BITS-1:0]
              + rank[IDX_BITS-1:0];
        alloc_preg[i*PREG_BITS +: PREG_BITS] =
          entries[a_idx];
        rank = rank + CNT_BITS'(1);
      end
    end
  end

  // Accept frees lowest lane first while room remains.
  always_comb begin
    space = CNT_BITS'(FL_DEPTH) - num_free;
    acc = '0;
    wr_en = '0;
    drop = 1'b0;
    for (int k = 0; k < FREE_W; k++) begin
      wr_idx[k] = '0;
      if (free_valid[k]) begin
        if (acc < space) begin
          wr_en[k] = 1'b1;
          wr_idx[k] = tail[IDX_BITS-1:0]
                    + acc[IDX_BITS-1:0];
          acc = acc + CNT_BITS'(1);
        end else begin
          drop = 1'b1;
        end
      end
    end
  end

  // List storage: reset to the unmapped pregs, written by frees.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FL_DEPTH; i++) begin
        entries[i] <= PREG_BITS'(NUM_AREGS + i);
      end
    end else begin
      for (int k = 0; k < FREE_W; k++) begin
        if (wr_en[k]) begin
          entries[wr_idx[k]] <=
            free_addr[k*PREG_BITS +: PREG_BITS];
        end
      end
    end
  end

  // Pointers, checkpoints and sticky overflow flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head <= '0;
      tail <= CNT_BITS'(FL_DEPTH);
      overflow_err <= 1'b0;
      for (int t = 0; t < MAX_PREDICT_DEPTH; t++) begin
        ckpt_head[t] <= '0;
      end
    end else begin
      tail <= tail + acc;
      if (drop) begin
        overflow_err <= 1'b1;
      end
      if (branch_shootdown) begin
        head <= ckpt_head[shootdown_branch_tag];
      end else begin
        head <= head_adv;
        if (checkpoint_valid) begin
          ckpt_head[checkpoint_tag] <= head_adv;
        end
      end
    end
  end

endmodule

// File: tb/tb_freelist_rename_n.sv
// Randomized and directed bench for freelist_rename_n.
// Reference keeps unbounded alloc/free positions and a history map.
module tb_freelist_rename_n;
  localparam int NA = 16;
  localparam int AW = 2;
  localparam int FW = 2;
  localparam int MD = 4;
  localparam int PB = 7;
  localparam int TB = 2;
  localparam int FD = 64;
  localparam int CB = 7;

  logic clk = 1'b0;
  logic reset;
  logic alloc_valid;
  logic [AW-1:0] alloc_req;
  logic alloc_ready;
  logic [AW*PB-1:0] alloc_preg;
  logic [CB-1:0] num_free;
  logic checkpoint_valid;
  logic [TB-1:0] checkpoint_tag;
  logic branch_shootdown;
  logic [TB-1:0] shootdown_branch_tag;
  logic [FW-1:0] free_valid;
  logic [FW*PB-1:0] free_addr;
  logic overflow_err;

  freelist_rename_n dut (
    .clk(clk),
    .reset(reset),
    .alloc_valid(alloc_valid),
    .alloc_req(alloc_req),
    .alloc_ready(alloc_ready),
    .alloc_preg(alloc_preg),
    .num_free(num_free),
    .checkpoint_valid(checkpoint_valid),
    .checkpoint_tag(checkpoint_tag),
    .branch_shootdown(branch_shootdown),
    .shootdown_branch_tag(shootdown_branch_tag),
    .free_valid(free_valid),
    .free_addr(free_addr),
    .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  int passes = 0;
  int total = 0;

  // Reference: m_a = pregs ever handed out, m_f = pregs ever queued.
  int m_a;
  int m_f;
  int mem [int];
  int ck [MD];
  bit m_ovf;

  task automatic chk(string name, int act, int exp);
    total++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d want %0d",
                  name, act, exp);
  endtask

  function automatic int lane(int i);
    return int'(alloc_preg[i*PB +: PB]);
  endfunction

  function automatic int popc(logic [1:0] v);
    return int'(v[0]) + int'(v[1]);
  endfunction

  task automatic m_reset();
    m_a = 0;
    m_f = FD;
    mem.delete();
    for (int p = 0; p < FD; p++) mem[p] = NA + p;
    for (int t = 0; t < MD; t++) ck[t] = 0;
    m_ovf = 0;
  endtask

  task automatic compare();
    int nf, need, rk, e;
    bit rdy;
    nf = m_f - m_a;
    need = popc(alloc_req);
    rdy = !branch_shootdown && (nf >= need);
    chk("num_free", int'(num_free), nf);
    chk("alloc_ready", int'(alloc_ready), int'(rdy));
    chk("overflow_err", int'(overflow_err), int'(m_ovf));
    rk = 0;
    for (int i = 0; i < AW; i++) begin
      if (!alloc_req[i]) begin
        chk("idle_lane", lane(i), 0);
      end else begin
        if (rdy) begin
          e = mem[m_a + rk];
          chk("alloc_preg", lane(i), e);
        end
        rk++;
      end
    end
  endtask

  task automatic m_step();
    int nf, need, acc, na;
    bit fire;
    nf = m_f - m_a;
    need = popc(alloc_req);
    fire = alloc_valid && !branch_shootdown && nf >= need;
    acc = 0;
    for (int k = 0; k < FW; k++) begin
      if (free_valid[k]) begin
        if (acc < FD - nf) begin
          mem[m_f + acc] = int'(free_addr[k*PB +: PB]);
          acc++;
        end else begin
          m_ovf = 1;
        end
      end
    end
    m_f += acc;
    na = fire ? m_a + need : m_a;
    if (branch_shootdown) begin
      m_a = ck[shootdown_branch_tag];
    end else begin
      if (checkpoint_valid) ck[checkpoint_tag] = na;
      m_a = na;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    compare();
    m_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alloc_valid = 0;
    alloc_req = '0;
    checkpoint_valid = 0;
    checkpoint_tag = '0;
    branch_shootdown = 0;
    shootdown_branch_tag = '0;
    free_valid = '0;
    free_addr = '0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    m_reset();
    @(posedge clk);
    #1;
    reset = 0;
    #1;
  endtask

  int q [$];
  int tg;

  initial begin
    reset = 1;
    idle();
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 0;

    alloc_valid = 1;
    alloc_req = 2'b11;
    #1;
    chk("rst_nf", int'(num_free), 64);
    chk("rst_ready", int'(alloc_ready), 1);
    chk("rst_l0", lane(0), 16);
    chk("rst_l1", lane(1), 17);
    cycle();
    chk("f1_l0", lane(0), 18);
    chk("f1_l1", lane(1), 19);
    chk("f1_nf", int'(num_free), 62);
    idle();

    do_reset();
    alloc_valid = 1;
    alloc_req = 2'b10;
    #1;
    chk("sp_l1", lane(1), 16);
    chk("sp_l0", lane(0), 0);
    cycle();
    chk("sp_nf", int'(num_free), 63);
    alloc_req = 2'b00;
    cycle();
    chk("zero_nf", int'(num_free), 63);
    idle();

    do_reset();
    alloc_valid = 1;
    alloc_req = 2'b11;
    repeat (32) cycle();
    chk("ex_nf", int'(num_free), 0);
    alloc_req = 2'b01;
    #1;
    chk("ex_ready", int'(alloc_ready), 0);
    cycle();
    chk("ex_hold", int'(num_free), 0);
    free_valid = 2'b01;
    free_addr = 14'd16;
    cycle();
    free_valid = '0;
    #1;
    chk("ex_ready2", int'(alloc_ready), 1);
    chk("ex_l0", lane(0), 16);
    cycle();
    idle();

    do_reset();
    alloc_valid = 1;
    alloc_req = 2'b11;
    checkpoint_valid = 1;
    checkpoint_tag = 2'd2;
    cycle();
    checkpoint_valid = 0;
    repeat (2) cycle();
    chk("ck_nf", int'(num_free), 58);
    branch_shootdown = 1;
    shootdown_branch_tag = 2'd2;
    #1;
    chk("sd_ready", int'(alloc_ready), 0);
    cycle();
    branch_shootdown = 0;
    #1;
    chk("sd_nf", int'(num_free), 62);
    chk("sd_l0", lane(0), 18);
    chk("sd_l1", lane(1), 19);
    cycle();
    idle();

    do_reset();
    free_valid = 2'b11;
    free_addr = {7'd6, 7'd5};
    cycle();
    idle();
    #1;
    chk("ov_err", int'(overflow_err), 1);
    chk("ov_nf", int'(num_free), 64);
    repeat (2) cycle();
    chk("ov_sticky", int'(overflow_err), 1);
    alloc_valid = 1;
    alloc_req = 2'b11;
    #1;
    chk("ov_l0", lane(0), 16);
    chk("ov_l1", lane(1), 17);
    cycle();
    idle();

    do_reset();
    q.delete();
    alloc_valid = 1;
    alloc_req = 2'b11;
    #1;
    q.push_back(lane(0));
    q.push_back(lane(1));
    cycle();
    for (int j = 0; j < 100; j++) begin
      #1;
      if (j == 31) begin
        chk("wrap_l0", lane(0), 16);
        chk("wrap_l1", lane(1), 17);
      end
      q.push_back(lane(0));
      q.push_back(lane(1));
      free_valid = 2'b11;
      free_addr[PB-1:0] = PB'(q.pop_front());
      free_addr[2*PB-1:PB] = PB'(q.pop_front());
      cycle();
      chk("wrap_nf", int'(num_free), 62);
    end
    idle();

    do_reset();
    alloc_valid = 1;
    alloc_req = 2'b11;
    repeat (5) cycle();
    #2;
    reset = 1;
    #1;
    chk("ar_nf", int'(num_free), 64);
    chk("ar_ready", int'(alloc_ready), 1);
    chk("ar_l0", lane(0), 16);
    chk("ar_l1", lane(1), 17);
    m_reset();
    @(posedge clk);
    #1;
    reset = 0;
    #1;
    chk("ar2_l0", lane(0), 16);
    chk("ar2_l1", lane(1), 17);
    cycle();
    chk("ar3_l0", lane(0), 18);
    chk("ar3_l1", lane(1), 19);
    idle();

    do_reset();
    for (int n = 0; n < 3000; n++) begin
      alloc_valid = ($urandom % 4) != 0;
      alloc_req = 2'($urandom);
      free_valid = 2'($urandom);
      free_addr = 14'($urandom);
      checkpoint_valid = ($urandom % 4) == 0;
      checkpoint_tag = 2'($urandom);
      branch_shootdown = 0;
      shootdown_branch_tag = '0;
      if ($urandom % 10 == 0) begin
        tg = int'($urandom % MD);
        if (m_f - ck[tg] >= 0 &&
            m_f + popc(free_valid) - ck[tg] <= FD) begin
          branch_shootdown = 1;
          shootdown_branch_tag = 2'(tg);
        end
      end
      cycle();
    end
    idle();
    cycle();

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule

// File: doc/freelist_rename_n.md
Name: freelist_rename_n

Overview:
- Parametrised N-wide physical-register freelist for the rename stage; successor to the fixed 2-wide allocator.
- Circular FIFO of free preg indices with ALLOC_W allocate lanes and FREE_W free (retire) lanes.
- Per-branch-tag head checkpoints: a branch shootdown returns every preg allocated after that branch in one cycle.
- Sits between instruction decode and dispatch. Decode stalls on alloc_ready=0. The ROB/commit stage drives the free lanes.

Parameters:
- NUM_PREGS, 80, total physical registers.
- NUM_AREGS, 16, architectural registers. pregs 0..NUM_AREGS-1 are mapped at reset and are never in the list.
- ALLOC_W, 2, allocate lanes per cycle.
- FREE_W, 2, free lanes per cycle.
- MAX_PREDICT_DEPTH, 4, checkpoint slots (outstanding branch tags).
- Derived: PREG_BITS=$clog2(NUM_PREGS); TAG_BITS=$clog2(MAX_PREDICT_DEPTH); FL_DEPTH=NUM_PREGS-NUM_AREGS. FL_DEPTH must be a power of two; otherwise elaboration fails via $error.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- alloc_valid  in  1  decode group presented this cycle.
- alloc_req  in  ALLOC_W  per-lane "needs a destination preg" mask; any bit pattern is legal.
- alloc_ready  out  1  group can be granted this cycle.
- alloc_preg  out  ALLOC_W*PREG_BITS  preg assigned to each lane (lane i at bits [i*PREG_BITS +: PREG_BITS]).
- num_free  out  $clog2(FL_DEPTH)+1  current free count (registered state).
- checkpoint_valid  in  1  save a checkpoint for a branch in this group.
- checkpoint_tag  in  TAG_BITS  slot to write.
- branch_shootdown  in  1  mispredict recovery.
- shootdown_branch_tag  in  TAG_BITS  slot to restore.
- free_valid  in  FREE_W  per-lane free strobe.
- free_addr  in  FREE_W*PREG_BITS  pregs returned by commit.
- overflow_err  out  1  sticky: a free was attempted while the list was full.

Behaviour:
- State:
  - entries[FL_DEPTH] of PREG_BITS.
  - head and tail, each $clog2(FL_DEPTH)+1 bits including a phase bit.
  - ckpt_head[MAX_PREDICT_DEPTH].
  - overflow_err.
- num_free = tail - head (width-truncated subtraction).
- Reset (async, immediate):
  - entries[i]=NUM_AREGS+i; head=0; tail=FL_DEPTH (phase=1, so num_free=FL_DEPTH).
  - all ckpt_head=0; overflow_err=0.
- Reset mid-operation discards all in-flight allocations and checkpoints. Outputs follow reset on the same edge.
- Allocation (combinational outputs):
  - need = popcount(alloc_req).
  - alloc_ready = !branch_shootdown && (num_free >= need).
  - Lane i gets entries[(head + popcount(alloc_req[i-1:0])) mod FL_DEPTH], i.e. requesting lanes are packed in lane order.
  - Lanes with alloc_req[i]=0 output 0.
- Grant (fire) = alloc_valid && alloc_ready. On fire at posedge, head += need. need=0 fires with no head change.
- Grant is all-or-nothing; there are no partial grants.
- Same-cycle frees are not counted toward alloc_ready. The count used is the registered one.
- Free:
  - Each set free_valid lane writes entries[tail mod FL_DEPTH + k], where k = rank among set free lanes in lane order.
  - tail += popcount(free_valid).
  - If num_free + popcount(free_valid) > FL_DEPTH, only the lanes that fit are accepted (lowest lanes first). The rest are dropped and overflow_err sets and stays set until reset.
  - Frees are always applied, including during a shootdown cycle.
- Checkpoint: on checkpoint_valid && !branch_shootdown, ckpt_head[checkpoint_tag] <= head-after-this-cycle's-fire (head+need if fire, else head).
- Shootdown: on branch_shootdown, head <= ckpt_head[shootdown_branch_tag].
  - Allocation and checkpoint writes are suppressed that cycle.
  - Tail is unaffected.
- Latency: alloc_preg is valid in the same cycle as the request. num_free and alloc_ready reflect a fire, free or shootdown one cycle later.
- Wrap-around: all indexing is mod FL_DEPTH. The phase bit distinguishes full from empty (head==tail with phases equal means empty).

Test Plan:
- Reset then check contents:
  - Required after reset: num_free=64, alloc_ready=1 for req=2'b11, alloc_preg lanes = {17,16}.
  - Fire once; required next cycle: lanes {19,18}, num_free=62.
- Sparse mask and zero-need fire:
  - req=2'b10 with head at preg 16 -> lane1=16, lane0=0, and after fire num_free=63.
  - req=2'b00 with alloc_valid=1 -> fire, num_free unchanged.
- Exhaustion:
  - Allocate 2/cycle for 32 cycles -> num_free=0; next req=2'b01 gives alloc_ready=0 and head holds.
  - free_valid=2'b01, free_addr=16 -> the following cycle alloc_ready=1 and lane0=16.
- Checkpoint and shootdown:
  - From reset, fire 2 (16,17) with checkpoint_valid tag 2, then fire 4 more -> num_free=58.
  - branch_shootdown tag 2 -> num_free=62 the next cycle, and the next grant returns 18,19.
  - A same-cycle alloc_valid is not granted.
- Overflow and wrap:
  - From reset (full), free_valid=2'b11 with addrs 5,6 -> both dropped, overflow_err=1, and it persists.
  - Run 100 allocate/free cycles at a steady rate of 2 -> pregs return in FIFO order across the wrap and num_free stays constant.
- Async reset mid-burst: assert reset between edges during fires -> outputs return to reset values immediately, and after release the first grant yields {17,16}.
